// File: rtl/shacc_seq_pkg.sv
// Shared types for the shift-accumulate stage and other latency-matching stages.
package shacc_seq_pkg;

   localparam int LAT_MAX = 8;

   typedef struct packed {
      logic v;
      logic sh;
      logic neg;
      logic done;
   } dly_stage_t;

   localparam int DLY_W = $bits(dly_stage_t);
   localparam int DLY_V_BIT = DLY_W - 1;

endpackage

// File: rtl/shacc_seq_ctrl_delay.sv
// LAT-deep, W-wide control shift register with synchronous clear.
// any_v reports whether any stage holds an entry whose valid bit (VBIT) is set.
module ctrl_delay #(
   parameter int W    = 4,
   parameter int LAT  = 2,
   parameter int VBIT = W - 1
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         any_v
);

   logic [LAT*W-1:0] sr_q;
   logic [LAT*W-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      sr_d[W-1:0] = din;
      for (int i = 1; i < LAT; i++) begin
         sr_d[i*W +: W] = sr_q[(i-1)*W +: W];
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   always_comb begin
      any_v = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         any_v = any_v | sr_q[i*W + VBIT];
      end
   end

   assign dout = sr_q[(LAT-1)*W +: W];

endmodule

// File: rtl/shacc_seq.sv
// Bit-serial shift-accumulate: aligns generator strobes with returning partial sums
// and folds them into a signed accumulator, emitting one result per vector.
module shacc_seq
   import shacc_seq_pkg::*;
#(
   parameter int BDIN = 10,
   parameter int BACC = 32,
   parameter int LAT  = 2
) (
   input  logic            clk,
   input  logic            clr,
   input  logic            en,
   input  logic            sh,
   input  logic            imsb,
   input  logic            wmsb,
   input  logic            vdone,
   input  logic            isigned,
   input  logic            wsigned,
   input  logic [BDIN-1:0] din,
   output logic [BACC-1:0] acc_out,
   output logic            acc_valid,
   output logic            busy
);

   dly_stage_t            stage_in;
   dly_stage_t            a_ctl;
   logic [DLY_W-1:0]      a_raw;
   logic                  any_v;

   logic [BACC-1:0]       acc_q, acc_d;
   logic [BACC-1:0]       acc_out_q, acc_out_d;
   logic                  acc_valid_q, acc_valid_d;
   logic                  started_q, started_d;

   logic [BACC-1:0]       term_ext;
   logic [BACC-1:0]       term;
   logic [BACC-1:0]       acc_sh;
   logic [BACC-1:0]       acc_next;

   // A sign-plane product is negative when exactly one operand is on its signed MSB plane.
   always_comb begin
      stage_in.v    = en;
      stage_in.sh   = sh;
      stage_in.neg  = (imsb & isigned) ^ (wmsb & wsigned);
      stage_in.done = vdone;
   end

   ctrl_delay #(
      .W    (DLY_W),
      .LAT  (LAT),
      .VBIT (DLY_V_BIT)
   ) u_ctrl_delay (
      .clk   (clk),
      .clr   (clr),
      .din   (stage_in),
      .dout  (a_raw),
      .any_v (any_v)
   );

   assign a_ctl = dly_stage_t'(a_raw);

   always_comb begin
      term_ext = {{(BACC-BDIN){din[BDIN-1]}}, din};
      term     = a_ctl.neg ? (~term_ext + 1'b1) : term_ext;
      acc_sh   = a_ctl.sh ? {acc_q[BACC-2:0], 1'b0} : acc_q;
      acc_next = acc_sh + term;
   end

   // Done clears acc in the same cycle so the next vector can start without a bubble.
   always_comb begin
      acc_d       = acc_q;
      acc_out_d   = acc_out_q;
      acc_valid_d = 1'b0;
      started_d   = started_q;
      if (a_ctl.v) begin
         if (a_ctl.done) begin
            acc_out_d   = acc_next;
            acc_valid_d = 1'b1;
            acc_d       = '0;
            started_d   = 1'b0;
         end else begin
            acc_d     = acc_next;
            started_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         acc_q       <= '0;
         acc_out_q   <= '0;
         acc_valid_q <= 1'b0;
         started_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         acc_out_q   <= acc_out_d;
         acc_valid_q <= acc_valid_d;
         started_q   <= started_d;
      end
   end

   assign acc_out   = acc_out_q;
   assign acc_valid = acc_valid_q;
   assign busy      = any_v | started_q;

endmodule

// File: tb/tb_shacc_seq.sv
// Directed bench for shacc_seq: a 32-bit and a 12-bit accumulator share one stimulus stream.
module tb_shacc_seq;

   localparam int BDIN = 10;

   logic            clk = 1'b0;
   logic            clr, en, sh, imsb, wmsb, vdone, isigned, wsigned;
   logic [BDIN-1:0] din;
   logic [BDIN-1:0] pipe0, pipe1;

   logic [31:0]     acc_out_a;
   logic            acc_valid_a, busy_a;
   logic [11:0]     acc_out_b;
   logic            acc_valid_b, busy_b;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   shacc_seq #(.BDIN(BDIN), .BACC(32), .LAT(2)) dut_a (
      .clk(clk), .clr(clr), .en(en), .sh(sh), .imsb(imsb), .wmsb(wmsb),
      .vdone(vdone), .isigned(isigned), .wsigned(wsigned), .din(din),
      .acc_out(acc_out_a), .acc_valid(acc_valid_a), .busy(busy_a)
   );

   shacc_seq #(.BDIN(BDIN), .BACC(12), .LAT(2)) dut_b (
      .clk(clk), .clr(clr), .en(en), .sh(sh), .imsb(imsb), .wmsb(wmsb),
      .vdone(vdone), .isigned(isigned), .wsigned(wsigned), .din(din),
      .acc_out(acc_out_b), .acc_valid(acc_valid_b), .busy(busy_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One generator cycle; d is the partial sum for this step, delivered two cycles later.
   task automatic cyc(input logic e, input logic s, input logic im, input logic wm,
                      input logic vd, input logic [BDIN-1:0] d);
      en = e; sh = s; imsb = im; wmsb = wm; vdone = vd;
      din   = pipe1;
      pipe1 = pipe0;
      pipe0 = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic result(input string tag, input logic [31:0] exp);
      chk({tag, "_valid"},   32'(acc_valid_a), 32'd1);
      chk({tag, "_out"},     acc_out_a,        exp);
      chk({tag, "_valid12"}, 32'(acc_valid_b), 32'd1);
      chk({tag, "_out12"},   32'(acc_out_b),   {20'd0, exp[11:0]});
   endtask

   // Called right after the done step: checks latency, the result, the one-cycle strobe and idle busy.
   task automatic finish_vec(input string tag, input logic [31:0] exp);
      idle();
      chk({tag, "_early"}, 32'(acc_valid_a), 32'd0);
      idle();
      result(tag, exp);
      idle();
      chk({tag, "_pulse"}, 32'(acc_valid_a), 32'd0);
      chk({tag, "_hold"},  acc_out_a,        exp);
      chk({tag, "_busy"},  32'(busy_a),      32'd0);
   endtask

   initial begin
      clr = 1'b1; en = 1'b0; sh = 1'b0; imsb = 1'b0; wmsb = 1'b0; vdone = 1'b0;
      isigned = 1'b0; wsigned = 1'b0; din = '0; pipe0 = '0; pipe1 = '0;
      idle();
      idle();
      chk("rst_out",    acc_out_a,         32'd0);
      chk("rst_valid",  32'(acc_valid_a),  32'd0);
      chk("rst_busy",   32'(busy_a),       32'd0);
      chk("rst_busy12", 32'(busy_b),       32'd0);
      clr = 1'b0;

      // unsigned single step
      cyc(1, 0, 0, 0, 1, 10'd5);
      chk("t1_busy", 32'(busy_a), 32'd1);
      finish_vec("t1", 32'd5);

      // unsigned shift sequence: ((3*2+2+1)*2)+4
      cyc(1, 0, 0, 0, 0, 10'd3);
      cyc(1, 1, 0, 0, 0, 10'd2);
      cyc(1, 0, 0, 0, 0, 10'd1);
      cyc(1, 1, 0, 0, 1, 10'd4);
      finish_vec("t2", 32'd22);

      // signed input MSB plane: -7*2+3
      isigned = 1'b1; wsigned = 1'b0;
      cyc(1, 0, 1, 0, 0, 10'd7);
      cyc(1, 1, 0, 0, 1, 10'd3);
      finish_vec("t3a", 32'hFFFF_FFF5);
      // both operands on signed MSB planes: negations cancel
      isigned = 1'b1; wsigned = 1'b1;
      cyc(1, 0, 1, 1, 1, 10'd7);
      finish_vec("t3b", 32'd7);
      // only the weight on its signed MSB plane
      isigned = 1'b0; wsigned = 1'b1;
      cyc(1, 0, 0, 1, 1, 10'd7);
      finish_vec("t3c", 32'hFFFF_FFF9);
      isigned = 1'b0; wsigned = 1'b0;

      // back-to-back vectors, second one with a two-cycle bubble
      cyc(1, 0, 0, 0, 1, 10'd9);
      cyc(1, 0, 0, 0, 0, 10'd1);
      idle();
      result("t4a", 32'd9);
      idle();
      chk("t4_gap", 32'(acc_valid_a), 32'd0);
      cyc(1, 0, 0, 0, 1, 10'd2);
      finish_vec("t4b", 32'd3);

      // wrap: 7665 in 32 bits, 0xDF1 in the 12-bit instance
      cyc(1, 1, 0, 0, 0, 10'd511);
      cyc(1, 1, 0, 0, 0, 10'd511);
      cyc(1, 1, 0, 0, 0, 10'd511);
      cyc(1, 1, 0, 0, 1, 10'd511);
      finish_vec("t5", 32'd7665);

      // clr in the middle of a vector
      cyc(1, 0, 0, 0, 0, 10'd10);
      cyc(1, 1, 0, 0, 0, 10'd20);
      clr = 1'b1;
      idle();
      clr = 1'b0;
      chk("t6_busy",  32'(busy_a),      32'd0);
      chk("t6_out",   acc_out_a,        32'd0);
      chk("t6_valid", 32'(acc_valid_a), 32'd0);
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("t6_novalid", 32'(acc_valid_a), 32'd0);
      end
      cyc(1, 0, 0, 0, 1, 10'd4);
      finish_vec("t6", 32'd4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
